// File: rtl/debounce_edge_det_pkg.sv
// debounce_edge_det_pkg: shared state encoding and default debounce length
package debounce_edge_det_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_WAIT_LOW  = 2'b11
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_edge_det_wrap_counter.sv
// wrap_counter: free-running wrapping event counter with clear priority
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // clear wins over a coincident increment; wraps naturally at 2**W
    always_comb begin
        count_d = clr ? '0 : inc ? count_q + W'(1) : count_q;
    end

    // count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/debounce_edge_det.sv
// debounce_edge_det: counter-based debounce FSM with registered level, edge pulses and rise counter
module debounce_edge_det
    import debounce_edge_det_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8,
    parameter int EVT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] event_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // next-state, counter and output decode; pulses default low every edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                state_d = din ? ST_WAIT_HIGH : ST_LOW;
                cnt_d   = din ? CNT_W'(1) : '0;
            end
            ST_WAIT_HIGH: begin
                if (!din) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                state_d = din ? ST_HIGH : ST_WAIT_LOW;
                cnt_d   = din ? '0 : CNT_W'(1);
            end
            ST_WAIT_LOW: begin
                if (din) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // state and output registers; reset discards any pending debounce
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    wrap_counter #(.W(EVT_W)) u_evt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_cnt),
        .inc  (rise_d),
        .count(event_count)
    );

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_debounce_edge_det.sv
// tb_debounce_edge_det: randomized and directed checks against a run-length reference model
module tb_debounce_edge_det;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       level, rise, fall;
    logic [7:0] event_count;

    int vectors = 0;
    int errors  = 0;

    logic       m_level, m_rise, m_fall;
    logic [7:0] m_cnt;
    int         m_run;

    debounce_edge_det #(.DEBOUNCE_CYCLES(N), .CNT_W(8), .EVT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .clr_cnt    (clr_cnt),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] got();
        return {level, rise, fall, event_count};
    endfunction

    function automatic logic [10:0] want();
        return {m_level, m_rise, m_fall, m_cnt};
    endfunction

    task automatic model_reset();
        m_level = 0; m_rise = 0; m_fall = 0; m_cnt = 0; m_run = 0;
    endtask

    // level flips once din has disagreed with it for N consecutive samples
    task automatic step(input logic d, input logic c);
        din = d;
        clr_cnt = c;
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            m_rise = 0;
            m_fall = 0;
            if (d != m_level) begin
                m_run++;
                if (m_run == N) begin
                    m_level = d;
                    m_rise = d;
                    m_fall = !d;
                    m_run = 0;
                end
            end else m_run = 0;
            m_cnt = c ? 8'd0 : m_cnt + 8'(m_rise);
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            vectors++;
            if (got() !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, got(), 11'd0);
            end
        end
        reset = 1;
        for (int i = 1; i <= 5; i++) begin
            step(1, 0);
            vectors++;
            if (got() !== want()) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %b want %b", i, got(), want());
            end
            if (i == 4) begin
                vectors++;
                if ({level, rise, event_count} !== {2'b11, 8'd1}) begin
                    errors++;
                    $display("FAIL first_rise: got %b want %b", {level, rise, event_count}, {2'b11, 8'd1});
                end
            end
            if (i == 5) begin
                vectors++;
                if (rise !== 1'b0) begin
                    errors++;
                    $display("FAIL rise_one_cycle: got %b want 0", rise);
                end
            end
        end
    endtask

    task automatic test_fall_rise();
        for (int i = 1; i <= 10; i++) begin
            step(i > 5, 0);
            vectors++;
            if (got() !== want()) begin
                errors++;
                $display("FAIL fall_rise step %0d: got %b want %b", i, got(), want());
            end
            if (i == 4 || i == 9) begin
                vectors++;
                if ({level, rise, fall} !== ((i == 4) ? 3'b001 : 3'b110)) begin
                    errors++;
                    $display("FAIL edge_pulse step %0d: got %b want %b", i, {level, rise, fall}, (i == 4) ? 3'b001 : 3'b110);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] c0;
        for (int i = 0; i < 4; i++) step(0, 0);
        c0 = m_cnt;
        for (int i = 0; i < 6; i++) begin
            step(i < 3, 0);
            vectors++;
            if (got() !== want() || level !== 1'b0 || event_count !== c0) begin
                errors++;
                $display("FAIL glitch step %0d: got %b want %b", i, got(), {3'b000, c0});
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) step(i >= 4, 0);
        step(1, 1);
        vectors++;
        if (event_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_idle: got %0d want 0", event_count);
        end
        for (int r = 1; r <= 256; r++) begin
            for (int i = 0; i < 8; i++) begin
                step(i >= 4, 0);
                vectors++;
                if (got() !== want()) begin
                    errors++;
                    $display("FAIL wrap rise %0d step %0d: got %b want %b", r, i, got(), want());
                end
            end
            if (r >= 255) begin
                vectors++;
                if (event_count !== 8'(r)) begin
                    errors++;
                    $display("FAIL wrap_value rise %0d: got %0d want %0d", r, event_count, 8'(r));
                end
            end
        end
        for (int i = 0; i < 8; i++) step(i >= 4, i == 7);
        vectors++;
        if ({rise, event_count} !== {1'b1, 8'd0} || got() !== want()) begin
            errors++;
            $display("FAIL clr_on_rise: got %b want %b", {rise, event_count}, {1'b1, 8'd0});
        end
    endtask

    task automatic test_reset_midwait();
        for (int i = 0; i < 4; i++) step(0, 0);
        for (int i = 0; i < 3; i++) step(1, 0);
        #3 reset = 0;
        #1 model_reset();
        vectors++;
        if (got() !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", got(), 11'd0);
        end
        step(1, 0);
        vectors++;
        if (got() !== 11'd0) begin
            errors++;
            $display("FAIL reset_no_rise: got %b want %b", got(), 11'd0);
        end
        reset = 1;
        for (int i = 0; i < 6; i++) begin
            step(0, 0);
            vectors++;
            if (got() !== want() || level !== 1'b0) begin
                errors++;
                $display("FAIL post_reset step %0d: got %b want %b", i, got(), want());
            end
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 20; i++) begin
            step(i[0], 0);
            vectors++;
            if ({level, rise, fall} !== 3'b000 || got() !== want()) begin
                errors++;
                $display("FAIL alternate step %0d: got %b want %b", i, got(), want());
            end
        end
    endtask

    task automatic test_random();
        logic d = 0;
        int   run = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run == 0) begin
                d = ~d;
                run = $urandom_range(1, 2 * N);
            end
            run--;
            step(d, $urandom_range(0, 31) == 0);
            vectors++;
            if (got() !== want() || (rise & fall) !== 1'b0) begin
                errors++;
                $display("FAIL random step %0d: got %b want %b", i, got(), want());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fall_rise();
        test_glitch();
        test_wrap();
        test_reset_midwait();
        test_alternate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
